// File: rtl/maxplus_accum_if.sv
// Handshake bundle between the max-plus reducer, the running-max accumulator
// and the downstream consumer of finished output elements.
interface maxplus_accum_if #(
  parameter int W   = 16,
  parameter int K_W = 8
);
  logic           start;
  logic [W-1:0]   init;
  logic [K_W-1:0] len;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [W-1:0]   acc_out;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           busy;

  modport master (
    output start, init, len, in_valid, in_data, out_ready,
    input  in_ready, acc_out, out_valid, out_data, busy
  );

  modport slave (
    input  start, init, len, in_valid, in_data, out_ready,
    output in_ready, acc_out, out_valid, out_data, busy
  );
endinterface

// File: rtl/maxplus_accum.sv
// Running-max accumulator behind the 5-input max reducer: folds one reduced
// k-step per beat, counts beats per tile and parks the result in a one-entry output register.
module maxplus_accum #(
  parameter int W   = 16,
  parameter int K_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  maxplus_accum_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   acc_reg, acc_next;
  logic [K_W-1:0] cnt_reg, cnt_next;
  logic [K_W-1:0] len_reg, len_next;
  logic [W-1:0]   out_data_reg, out_data_next;
  logic           out_valid_reg, out_valid_next;
  logic           out_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_free = !out_valid_reg || bus.out_ready;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;

    // Drain first; a reload in HOLD on the same edge overrides it below.
    if (out_valid_reg && bus.out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          acc_next   = bus.init;
          len_next   = bus.len;
          cnt_next   = '0;
          state_next = (bus.len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          // Re-folding here keeps the result right even if the reducer's
          // accumulator operand is not tied to acc_out.
          acc_next = (bus.in_data >= acc_reg) ? bus.in_data : acc_reg;
          cnt_next = cnt_reg + K_W'(1);
          if (cnt_reg == len_reg - K_W'(1)) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_data_next  = acc_reg;
          out_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == ACC);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.acc_out   = acc_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_maxplus_accum.sv
// Randomized scoreboard bench for maxplus_accum: expected tile results are
// the plain maximum of init and all beats, queued at start and checked by a monitor.
module tb_maxplus_accum;
  logic clk;
  logic rst;
  int   total;
  int   passed;
  bit   rand_ready;
  logic [15:0] exp_q[$];
  logic [15:0] beats[$];
  logic [15:0] held;
  bit   stall;

  maxplus_accum_if #(.W(16), .K_W(8)) bus ();

  maxplus_accum #(.W(16), .K_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_acc_out"}, 32'(bus.acc_out), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 300 && bus.busy; i++) tick;
    check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic pulse_reset;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_zero("async_rst");
    tick;
    rst = 1'b0;
  endtask

  // Runs one tile from start to HOLD entry; expected result is max(init, beats).
  // gap: 0 none, 1 random idle cycles, 2 idle cycle between beats.
  // noise: keep start asserted with garbage init/len while the tile is busy.
  task automatic do_tile(input logic [15:0] init_v, input logic [7:0] n,
                         input int gap, input bit noise);
    logic [15:0] run;
    logic [15:0] expv;
    expv = init_v;
    foreach (beats[i]) if (beats[i] > expv) expv = beats[i];
    exp_q.push_back(expv);
    bus.start    = 1'b1;
    bus.init     = init_v;
    bus.len      = n;
    bus.in_valid = noise;
    bus.in_data  = 16'hFFFF;
    tick;
    bus.start    = noise;
    bus.init     = 16'($urandom);
    bus.len      = 8'($urandom);
    check("start_acc", 32'(bus.acc_out), 32'(init_v));
    check("start_busy", 32'(bus.busy), 32'd1);
    run = init_v;
    for (int i = 0; i < int'(n); i++) begin
      if ((gap == 1 && $urandom_range(0, 1) == 1) || (gap == 2 && i > 0)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        tick;
        check("gap_acc", 32'(bus.acc_out), 32'(run));
      end
      check("beat_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      tick;
      if (beats[i] >= run) run = beats[i];
      check("beat_acc", 32'(bus.acc_out), 32'(run));
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("hold_entry", 32'(bus.in_ready), 32'd0);
  endtask

  // Scoreboard monitor: pops an expectation whenever a result is handed over.
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_data", 32'(bus.out_data), 32'(held));
        check("stall_valid", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          $display("result out_data=0x%04h expected=0x%04h", bus.out_data, e);
          check("result", 32'(bus.out_data), 32'(e));
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = bus.out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; passed = 0; rand_ready = 1'b0; stall = 1'b0; held = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.init = '0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    tick; tick;
    check_zero("reset");
    rst = 1'b0;
    tick;

    // Basic tile: acc_out 5,5,16,16,16 then result one cycle after HOLD.
    beats = '{16'h0003, 16'h0010, 16'h000F, 16'h0001};
    do_tile(16'h0005, 8'd4, 0, 1'b0);
    check("t1_busy_hold", 32'(bus.busy), 32'd1);
    check("t1_valid_early", 32'(bus.out_valid), 32'd0);
    tick;
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_data", 32'(bus.out_data), 32'h10);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // Zero-length tile.
    beats = '{};
    do_tile(16'h1234, 8'd0, 0, 1'b0);
    check("t2_valid_early", 32'(bus.out_valid), 32'd0);
    tick;
    check("t2_valid", 32'(bus.out_valid), 32'd1);
    check("t2_data", 32'(bus.out_data), 32'h1234);
    check("t2_in_ready", 32'(bus.in_ready), 32'd0);
    tick;

    // Back-to-back tiles under backpressure, same-edge drain and reload.
    bus.out_ready = 1'b0;
    beats = '{16'h00A0, 16'h0010};
    do_tile(16'h0000, 8'd2, 0, 1'b0);
    wait_idle;
    beats = '{16'h0050, 16'h00B0};
    do_tile(16'h0000, 8'd2, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t3_stuck_busy", 32'(bus.busy), 32'd1);
      check("t3_stuck_ready", 32'(bus.in_ready), 32'd0);
      check("t3_first_data", 32'(bus.out_data), 32'h00A0);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check("t3_reload_valid", 32'(bus.out_valid), 32'd1);
    check("t3_reload_data", 32'(bus.out_data), 32'h00B0);
    check("t3_reload_idle", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b1;
    tick;

    // in_valid gaps and unsigned ordering.
    beats = '{16'hFFFF, 16'h0000, 16'h8000};
    do_tile(16'h0000, 8'd3, 2, 1'b0);
    wait_idle;
    beats = '{16'h8000, 16'h0001};
    do_tile(16'h7FFF, 8'd2, 2, 1'b0);
    wait_idle;
    tick;

    // Async reset mid-ACC after 2 of 4 beats.
    bus.start = 1'b1; bus.init = 16'h0009; bus.len = 8'd4;
    tick;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0020;
    tick;
    bus.in_data = 16'h0030;
    tick;
    bus.in_valid = 1'b0;
    pulse_reset;
    // Async reset while a result is pending.
    bus.out_ready = 1'b0;
    beats = '{16'h0044};
    do_tile(16'h0011, 8'd1, 0, 1'b0);
    tick;
    check("t5_pending", 32'(bus.out_valid), 32'd1);
    pulse_reset;
    bus.out_ready = 1'b1;
    beats = '{16'h0003};
    do_tile(16'h0007, 8'd1, 0, 1'b0);
    wait_idle;
    tick;

    // start ignored in ACC and HOLD.
    bus.out_ready = 1'b0;
    beats = '{16'h0010, 16'h0020};
    do_tile(16'h0000, 8'd2, 0, 1'b0);
    wait_idle;
    beats = '{16'h0005, 16'h0099, 16'h0007};
    do_tile(16'h0008, 8'd3, 1, 1'b1);
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.init = 16'($urandom);
      bus.len  = 8'($urandom);
      tick;
      check("t6_hold_busy", 32'(bus.busy), 32'd1);
      check("t6_hold_acc", 32'(bus.acc_out), 32'h0099);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle;
    tick;

    // Randomized tiles with random consumer backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(0, 6);
      beats = '{};
      for (int i = 0; i < n; i++) beats.push_back(16'($urandom));
      do_tile(16'($urandom), 8'(n), 1, 1'($urandom_range(0, 1)));
      wait_idle;
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/maxplus_accum.md
# maxplus_accum

Running-max accumulator that sits directly downstream of the 5-input max reducer in the max-plus extended tensor core datapath. It holds the per-output-element accumulator, drives it back to the reducer's accumulator operand, folds each reduced k-step result into it, counts k-steps per tile, and emits the finished element over a valid/ready handshake. A one-entry output register lets the next tile start accumulating while the previous result waits for the consumer.

## Interface
- W, 16: data width; unsigned compare, same as the max reducer.
- K_W, 8: k-step counter and `len` width; max tile length 2^K_W-1.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle tile start; sampled only in IDLE.
- init  in  W  initial accumulator value (e.g. incoming C element), captured on accepted start.
- len  in  K_W  number of k-step beats in the tile, captured on accepted start.
- in_valid  in  1  reducer result valid.
- in_ready  out  1  block accepts `in_data` this cycle.
- in_data  in  W  reducer output for one k-step.
- acc_out  out  W  registered accumulator, wired to the reducer's accumulator input.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  finished element.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACC, HOLD.
- IDLE: in_ready=0. On start: acc<=init, len_q<=len, cnt<=0; len==0 -> HOLD, else -> ACC. start ignored in ACC/HOLD.
- ACC: in_ready=1. Beat accepted when in_valid&&in_ready: acc <= (in_data >= acc) ? in_data : acc (idempotent with reducer's own fold; protects against an untied accumulator operand). cnt<=cnt+1. If cnt==len_q-1 on that beat -> HOLD. cnt never wraps: exits at len_q.
- HOLD: in_ready=0. Output register free when !out_valid || out_ready. If free: out_data<=acc, out_valid<=1, -> IDLE. Else stay HOLD, acc unchanged.
- Output register: out_valid cleared on out_valid&&out_ready unless reloaded the same edge (reload wins, out_valid stays 1, new data). out_data stable while out_valid&&!out_ready.
- acc_out = acc at all times; not cleared when returning to IDLE (keeps last result until next start).
- Arithmetic: pure unsigned W-bit compare/select, no overflow possible.

## Timing
- Reset (async, immediate): state=IDLE, acc=0, cnt=0, len_q=0, out_data=0, out_valid=0; therefore in_ready=0, busy=0, acc_out=0.
- Reset mid-tile or with out_valid=1: all state discarded, pending result lost.
- acc_out reflects a beat's contribution from the edge the beat is accepted; reducer sees updated accumulator next cycle.
- Latency: final beat accepted at edge t -> HOLD at t; earliest out_valid=1 after edge t+1. len==0: start at edge t -> out_valid=1 after t+1 (out_data=init).
- Earliest next start: the cycle after returning to IDLE (edge t+2 for final beat at t).
- Backpressure: out_ready low holds result; a following tile may run fully in ACC, then stalls in HOLD until out register frees. Same-cycle drain and reload in HOLD is allowed (no bubble).
- in_valid gaps in ACC are allowed; cnt and acc hold.
- start and in_valid in the same IDLE cycle: only start takes effect; no beat accepted.

## Test plan
- Reset then start init=0x0005 len=4, beats 0x0003,0x0010,0x000F,0x0001, out_ready=1 -> out_valid one cycle after HOLD entry, out_data=0x0010, acc_out sequence 5,5,16,16,16.
- start init=0x1234 len=0 -> out_data=0x1234 with out_valid asserted after the second edge; in_ready stays 0.
- Two back-to-back tiles (len=2, results 0x00A0 then 0x00B0) with out_ready=0 until second tile reaches HOLD -> first result held stable, block stays in HOLD with in_ready=0; raise out_ready for one cycle -> 0x00A0 accepted and 0x00B0 loaded same edge, out_valid stays 1.
- Beats with in_valid toggling every other cycle, len=3, values 0xFFFF,0x0000,0x8000 -> exactly 3 beats counted, out_data=0xFFFF, unsigned ordering confirmed (0x8000 > 0x7FFF case included in a variant).
- Assert rst asynchronously mid-ACC after 2 of 4 beats and again while out_valid=1 -> all outputs zero immediately, next tile init=7 len=1 beat 3 -> out_data=7.
- start pulsed during ACC and HOLD -> ignored; len_q, cnt, acc unaffected; result matches the original tile.
